rotate_stage_ctrl: RTL and testbench

// - Rho (lane-rotate) stage of the encoder round, directly upstream of the permute stage.
// - Walks the 25 lanes of the 5x5 state held in the shared state memory.
// - Per lane: reads the lane, rotates it left by its fixed rho offset, writes it back in place.
// - After lane 24 is written, pulses permute_start, then holds until permute_done returns.

---
 rtl/rotate_stage_ctrl_pkg.sv | 51 +++++
 rtl/rotate_stage_ctrl_lane_rotl.sv | 37 +++
 rtl/rotate_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_rotate_stage_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_stage_ctrl_pkg.sv
// Shared definitions for the rho (lane-rotate) stage: FSM encodings, lane count
// and the fixed per-lane rotation offsets.
package rotate_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StLatch = 3'd2,
        StWrite = 3'd3,
        StKick  = 3'd4,
        StWaitP = 3'd5
    } state_e;

    localparam int unsigned NUM_LANES = 25;
    localparam int unsigned ROT_AMT_W = 6;

    // Rho offset for lane index x + 5*y, before reduction modulo the lane width
    function automatic int unsigned rho_off(input logic [4:0] idx);
        int unsigned r;
        case (idx)
            5'd0:    r = 0;
            5'd1:    r = 1;
            5'd2:    r = 62;
            5'd3:    r = 28;
            5'd4:    r = 27;
            5'd5:    r = 36;
            5'd6:    r = 44;
            5'd7:    r = 6;
            5'd8:    r = 55;
            5'd9:    r = 20;
            5'd10:   r = 3;
            5'd11:   r = 10;
            5'd12:   r = 43;
            5'd13:   r = 25;
            5'd14:   r = 39;
            5'd15:   r = 41;
            5'd16:   r = 45;
            5'd17:   r = 15;
            5'd18:   r = 21;
            5'd19:   r = 8;
            5'd20:   r = 18;
            5'd21:   r = 2;
            5'd22:   r = 61;
            5'd23:   r = 56;
            5'd24:   r = 14;
            default: r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rotate_stage_ctrl_lane_rotl.sv
// Combinational barrel rotate-left of one lane by a 6-bit amount.
module rotate_stage_ctrl_lane_rotl
    import rotate_stage_ctrl_pkg::*;
#(
    parameter int unsigned LANE_W = 64
) (
    input  logic [LANE_W-1:0]    i_data,
    input  logic [ROT_AMT_W-1:0] i_amt,
    output logic [LANE_W-1:0]    o_data
);

    // Rotate by a fixed distance; a zero distance passes the lane through
    function automatic logic [LANE_W-1:0] rotl_by(input logic [LANE_W-1:0] v,
                                                  input int unsigned s);
        if (s == 0) begin
            return v;
        end
        return (v << s) | (v >> (LANE_W - s));
    endfunction

    logic [LANE_W-1:0] w_stage [ROT_AMT_W+1];

    // One stage per amount bit, each rotating by 2^k (reduced modulo the lane width)
    always_comb begin
        w_stage[0] = i_data;
        for (int k = 0; k < ROT_AMT_W; k++) begin
            if (i_amt[k]) begin
                w_stage[k+1] = rotl_by(w_stage[k], (32'd1 << k) % LANE_W);
            end else begin
                w_stage[k+1] = w_stage[k];
            end
        end
    end

    assign o_data = w_stage[ROT_AMT_W];

endmodule

// File: rtl/rotate_stage_ctrl.sv
// Rho stage controller: walks the 25 state lanes, rotating each in place, then
// hands off to the permute stage and waits for it to finish.
module rotate_stage_ctrl
    import rotate_stage_ctrl_pkg::*;
#(
    parameter int unsigned LANE_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LANE_W-1:0] i_mem_rdata,
    input  logic              i_permute_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [LANE_W-1:0] o_mem_wdata,
    output logic              o_permute_start,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_LANES - 1);

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_d;
    logic [LANE_W-1:0]   r_lane_q;
    logic [LANE_W-1:0]   w_lane_d;
    logic [ROT_AMT_W-1:0] w_rot_amt;
    logic [LANE_W-1:0]   w_rotated;

    assign w_rot_amt = ROT_AMT_W'(rho_off(5'(r_idx)) % LANE_W);

    rotate_stage_ctrl_lane_rotl #(
        .LANE_W (LANE_W)
    ) u_lane_rotl (
        .i_data (r_lane_q),
        .i_amt  (w_rot_amt),
        .o_data (w_rotated)
    );

    // Next-state, lane index and lane holding register updates
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_lane_d  = r_lane_q;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StRead;
                    w_idx_d   = '0;
                end
            end
            StRead: begin
                w_state_d = StLatch;
            end
            StLatch: begin
                w_lane_d  = i_mem_rdata;
                w_state_d = StWrite;
            end
            StWrite: begin
                if (r_idx == LastIdx) begin
                    w_state_d = StKick;
                end else begin
                    w_idx_d   = r_idx + ADDR_W'(1);
                    w_state_d = StRead;
                end
            end
            StKick: begin
                w_state_d = StWaitP;
            end
            StWaitP: begin
                if (i_permute_done) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output decode straight from the current state
    always_comb begin
        o_mem_addr      = '0;
        o_mem_rd        = 1'b0;
        o_mem_wr        = 1'b0;
        o_mem_wdata     = '0;
        o_permute_start = 1'b0;
        o_done          = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_done = 1'b1;
            end
            StRead: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = r_idx;
            end
            StWrite: begin
                o_mem_wr    = 1'b1;
                o_mem_addr  = r_idx;
                o_mem_wdata = w_rotated;
            end
            StKick: begin
                o_permute_start = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset aborts any pass in flight without touching memory
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_lane_q <= '0;
        end else begin
            r_state  <= w_state_d;
            r_idx    <= w_idx_d;
            r_lane_q <= w_lane_d;
        end
    end

endmodule

// File: tb/tb_rotate_stage_ctrl.sv
// Directed bench for rotate_stage_ctrl with a small state-memory model.
module tb_rotate_stage_ctrl;

    localparam int unsigned LANE_W = 64;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              permute_done;
    logic [LANE_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd;
    logic              o_mem_wr;
    logic [LANE_W-1:0] o_mem_wdata;
    logic              o_permute_start;
    logic              o_done;

    rotate_stage_ctrl #(
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_mem_rdata     (mem_rdata),
        .i_permute_done  (permute_done),
        .o_mem_addr      (o_mem_addr),
        .o_mem_rd        (o_mem_rd),
        .o_mem_wr        (o_mem_wr),
        .o_mem_wdata     (o_mem_wdata),
        .o_permute_start (o_permute_start),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference rotate: bit b moves to (b + r) mod 64
    int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                        41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    function automatic logic [63:0] rotl_model(input logic [63:0] v, input int r);
        logic [63:0] o;
        for (int b = 0; b < 64; b++) begin
            o[(b + r) % 64] = v[b];
        end
        return o;
    endfunction

    // Memory model and pass statistics, all observed on the falling edge
    logic [63:0] mem [25];
    int          cyc = 0;
    int          wr_count = 0;
    int          rd_wr_both = 0;
    int          gap_err = 0;
    int          kick_count = 0;
    int          prev_wr_cyc = -1;
    int          wr_per_addr [25];
    logic        rd_pend = 1'b0;
    logic [4:0]  rd_addr_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_pend) mem_rdata <= mem[rd_addr_q];
        rd_pend   <= o_mem_rd;
        rd_addr_q <= o_mem_addr;
        if (o_mem_rd && o_mem_wr) rd_wr_both <= rd_wr_both + 1;
        if (o_mem_wr) begin
            mem[o_mem_addr]         <= o_mem_wdata;
            wr_count                <= wr_count + 1;
            wr_per_addr[o_mem_addr] <= wr_per_addr[o_mem_addr] + 1;
            if (prev_wr_cyc >= 0 && cyc - prev_wr_cyc != 3) gap_err <= gap_err + 1;
            prev_wr_cyc <= cyc;
        end
        if (o_permute_start) kick_count <= kick_count + 1;
    end

    task automatic clear_stats();
        wr_count    = 0;
        rd_wr_both  = 0;
        gap_err     = 0;
        kick_count  = 0;
        prev_wr_cyc = -1;
        for (int i = 0; i < 25; i++) wr_per_addr[i] = 0;
    endtask

    task automatic preload_onehot();
        for (int i = 0; i < 25; i++) mem[i] = 64'h1 << i;
    endtask

    task automatic start_pass(output int sc);
        @(negedge clk);
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_kick(input string name);
        for (int i = 0; i < 200 && !o_permute_start; i++) @(negedge clk);
        chk(name, 64'(o_permute_start), 64'd1);
    endtask

    task automatic check_pass_stats(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 25; i++) if (wr_per_addr[i] != 1) bad++;
        chk({tag, "_writes"}, 64'(wr_count), 64'd25);
        chk({tag, "_write_gap"}, 64'(gap_err), 64'd0);
        chk({tag, "_once_per_addr"}, 64'(bad), 64'd0);
        chk({tag, "_rd_wr_overlap"}, 64'(rd_wr_both), 64'd0);
        chk({tag, "_kicks"}, 64'(kick_count), 64'd1);
    endtask

    typedef struct {
        int          lane;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int sc;
        int bad;

        // Hand-computed results for a pass over lane i = 1 << i
        vecs[0] = '{lane: 0,  exp: 64'h0000_0000_0000_0001};
        vecs[1] = '{lane: 1,  exp: 64'h0000_0000_0000_0004};
        vecs[2] = '{lane: 2,  exp: 64'h0000_0000_0000_0001};
        vecs[3] = '{lane: 3,  exp: 64'h0000_0000_8000_0000};
        vecs[4] = '{lane: 8,  exp: 64'h8000_0000_0000_0000};
        vecs[5] = '{lane: 10, exp: 64'h0000_0000_0000_2000};
        vecs[6] = '{lane: 22, exp: 64'h0000_0000_0008_0000};
        vecs[7] = '{lane: 24, exp: 64'h0000_0040_0000_0000};

        // Reset held with start high: nothing moves
        rst_n = 1'b0;
        start = 1'b1;
        permute_done = 1'b0;
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_done", 64'(o_done), 64'd1);
            chk("rst_strobes", {61'd0, o_mem_rd, o_mem_wr, o_permute_start}, 64'd0);
            chk("rst_addr", 64'(o_mem_addr), 64'd0);
        end
        chk("rst_wdata", o_mem_wdata, 64'd0);
        chk("rst_no_writes", 64'(wr_count), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 64'(o_done), 64'd1);

        // Pass 1: full walk, then a long downstream stall
        preload_onehot();
        clear_stats();
        start_pass(sc);
        wait_kick("p1_kick_timeout");
        chk("p1_kick_cycle", 64'(cyc - sc), 64'd76);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_done || o_mem_rd || o_mem_wr || o_permute_start) bad++;
        end
        chk("p1_waitp_hold", 64'(bad), 64'd0);
        permute_done = 1'b1;
        @(negedge clk);
        chk("p1_done_after_pdone", 64'(o_done), 64'd1);
        permute_done = 1'b0;
        @(negedge clk);
        check_pass_stats("p1");
        for (int v = 0; v < 8; v++) begin
            chk($sformatf("p1_lane%0d", vecs[v].lane), mem[vecs[v].lane], vecs[v].exp);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (mem[i] !== rotl_model(64'h1 << i, rho_tb[i] % 64)) bad++;
        end
        chk("p1_all_lanes_model", 64'(bad), 64'd0);

        // Pass 2: wrap lane, stray start during WRITE of lane 10, permute_done pre-high
        preload_onehot();
        mem[21] = 64'h8000_0000_0000_0001;
        clear_stats();
        start_pass(sc);
        for (int i = 0; i < 100 && !(o_mem_wr && o_mem_addr == 5'd10); i++) @(negedge clk);
        chk("p2_saw_lane10_write", 64'(o_mem_wr && o_mem_addr == 5'd10), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_kick("p2_kick_timeout");
        chk("p2_kick_cycle", 64'(cyc - sc), 64'd76);
        permute_done = 1'b1;
        @(negedge clk);
        chk("p2_waitp_done_low", 64'(o_done), 64'd0);
        @(negedge clk);
        chk("p2_idle_after_2", 64'(o_done), 64'd1);
        permute_done = 1'b0;
        repeat (20) @(negedge clk);
        check_pass_stats("p2");
        chk("p2_no_second_pass", 64'(o_done), 64'd1);
        chk("p2_lane21_wrap", mem[21], 64'h0000_0000_0000_0006);
        chk("p2_lane10", mem[10], 64'h0000_0000_0000_2000);

        // Pass 3: reset during READ of lane 7, then a fresh pass from lane 0
        preload_onehot();
        clear_stats();
        start_pass(sc);
        for (int i = 0; i < 100 && !(o_mem_rd && o_mem_addr == 5'd7); i++) @(negedge clk);
        chk("p3_saw_lane7_read", 64'(o_mem_rd && o_mem_addr == 5'd7), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("p3_abort_done", 64'(o_done), 64'd1);
        chk("p3_abort_strobes", {61'd0, o_mem_rd, o_mem_wr, o_permute_start}, 64'd0);
        chk("p3_abort_addr", 64'(o_mem_addr), 64'd0);
        chk("p3_abort_wdata", o_mem_wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("p3_prior_writes", 64'(wr_count), 64'd7);
        clear_stats();
        start_pass(sc);
        chk("p3_restart_rd", 64'(o_mem_rd), 64'd1);
        chk("p3_restart_addr", 64'(o_mem_addr), 64'd0);
        wait_kick("p3_kick_timeout");
        permute_done = 1'b1;
        repeat (2) @(negedge clk);
        permute_done = 1'b0;
        @(negedge clk);
        check_pass_stats("p3");
        chk("p3_lane7", mem[7], rotl_model(64'h1 << 7, rho_tb[7]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
